loopback_checker: RTL

- Verilog-side consumer for a prsim co-simulation loop.
- Samples a stimulus bit that is driven into prsim, for example a clk_gen output handed over with $to_prsim.
- Samples the echo bit that prsim returns through $from_prsim.
- Checks that every stimulus transition comes back with the same value, in order, within a bounded number of clk cycles.
- Reports per-edge latency, counts, and sticky error flags to the bench.

---
 rtl/loopback_checker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/loopback_checker.sv
// ---------------------------------------------------------------------------
// loopback_checker
//   Verilog-side consumer for a prsim co-simulation loop. Every stimulus
//   transition driven into prsim is queued with a timestamp. The echo
//   returned from prsim must reproduce the same values, in order, within
//   MAX_LAT clk cycles. The block reports per-match latency, counts and
//   sticky error flags.
//
// Ports
//   clk          check clock
//   reset        synchronous, active-high
//   enable       when low, edges are ignored (sample registers still update)
//   stim_i       stimulus value as driven into prsim
//   echo_i       value returned from prsim
//   clear_err    one-cycle pulse; clears sticky errors and leaves FAULT
//   busy         FIFO non-empty
//   edge_count   stimulus edges accepted (saturating)
//   match_count  echoes matched (saturating)
//   last_lat     latency of the most recent match
//   peak_lat     maximum matched latency since reset
//   err_timeout  sticky; head entry aged past MAX_LAT
//   err_spurious sticky; echo edge with no or mismatching pending entry
//   err_overflow sticky; stimulus edge while FIFO full
//   state        0=IDLE 1=WAIT 2=FAULT
// ---------------------------------------------------------------------------
module loopback_checker #(
   parameter int unsigned MAX_LAT     = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned STOP_ON_ERR = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             stim_i,
   input  logic             echo_i,
   input  logic             clear_err,
   output logic             busy,
   output logic [CNT_W-1:0] edge_count,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] last_lat,
   output logic [CNT_W-1:0] peak_lat,
   output logic             err_timeout,
   output logic             err_spurious,
   output logic             err_overflow,
   output logic [1:0]       state
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CNT_W-1:0] LAT_MAX     = CNT_W'(MAX_LAT);
   localparam logic [CNT_W-1:0] TIMEOUT_AGE = CNT_W'(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = '1;
   localparam logic [CW-1:0]    FULL_CNT    = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FAULT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] ts_q;
   logic             stim_q, echo_q;

   // Pending stimulus entries: value and push timestamp
   logic             mem_val_q [DEPTH];
   logic [CNT_W-1:0] mem_ts_q  [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] last_lat_q, last_lat_d;
   logic [CNT_W-1:0] peak_lat_q, peak_lat_d;
   logic             err_to_q, err_to_d;
   logic             err_sp_q, err_sp_d;
   logic             err_ov_q, err_ov_d;
   logic             busy_q, busy_d;

   logic             head_val_c;
   logic [CNT_W-1:0] age_c;
   logic             empty_c, full_c, active_c;
   logic             stim_edge_c, echo_edge_c;
   logic             echo_act_c, push_req_c;
   logic             match_c, spur_c, tout_c, ovf_c;
   logic             pop_c, push_c, new_err_c;

   // Head inspection; modular subtraction keeps the age correct across wrap
   assign head_val_c  = mem_val_q[rd_ptr_q];
   assign age_c       = ts_q - mem_ts_q[rd_ptr_q];
   assign empty_c     = (cnt_q == '0);
   assign full_c      = (cnt_q == FULL_CNT);
   assign active_c    = (state_q != S_FAULT);

   assign stim_edge_c = (stim_i != stim_q);
   assign echo_edge_c = (echo_i != echo_q);
   assign echo_act_c  = echo_edge_c & enable & active_c;
   assign push_req_c  = stim_edge_c & enable & active_c;

   // Event decode: a matching echo at age MAX_LAT beats the timeout
   assign match_c   = echo_act_c & ~empty_c & (head_val_c == echo_i) & (age_c <= LAT_MAX);
   assign spur_c    = echo_act_c & (empty_c | (head_val_c != echo_i));
   assign tout_c    = active_c & ~empty_c & (age_c == TIMEOUT_AGE) & ~match_c;
   assign pop_c     = match_c | tout_c;
   // A pop in the same cycle frees the slot for a push into a full FIFO
   assign push_c    = push_req_c & (~full_c | pop_c);
   assign ovf_c     = push_req_c & full_c & ~pop_c;
   assign new_err_c = tout_c | spur_c | ovf_c;

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      edge_cnt_d  = edge_cnt_q;
      match_cnt_d = match_cnt_q;
      last_lat_d  = last_lat_q;
      peak_lat_d  = peak_lat_q;
      err_to_d    = (err_to_q & ~clear_err) | tout_c;
      err_sp_d    = (err_sp_q & ~clear_err) | spur_c;
      err_ov_d    = (err_ov_q & ~clear_err) | ovf_c;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (edge_cnt_q != CNT_SAT) edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c && !pop_c) cnt_d = cnt_q + CW'(1);
      if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);

      if (match_c) begin
         if (match_cnt_q != CNT_SAT) match_cnt_d = match_cnt_q + CNT_W'(1);
         last_lat_d = age_c;
         if (age_c > peak_lat_q) peak_lat_d = age_c;
      end

      case (state_q)
         S_FAULT: begin
            // Leaving FAULT discards whatever was pending when checking froze
            if (clear_err) begin
               state_d  = S_IDLE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               cnt_d    = '0;
            end
         end
         default: begin
            if ((STOP_ON_ERR != 0) && new_err_c) state_d = S_FAULT;
            else if (cnt_d != '0)                state_d = S_WAIT;
            else                                 state_d = S_IDLE;
         end
      endcase

      busy_d = (cnt_d != '0);
   end

   // Control and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ts_q        <= '0;
         stim_q      <= stim_i;
         echo_q      <= echo_i;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         edge_cnt_q  <= '0;
         match_cnt_q <= '0;
         last_lat_q  <= '0;
         peak_lat_q  <= '0;
         err_to_q    <= 1'b0;
         err_sp_q    <= 1'b0;
         err_ov_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ts_q        <= ts_q + CNT_W'(1);
         stim_q      <= stim_i;
         echo_q      <= echo_i;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         match_cnt_q <= match_cnt_d;
         last_lat_q  <= last_lat_d;
         peak_lat_q  <= peak_lat_d;
         err_to_q    <= err_to_d;
         err_sp_q    <= err_sp_d;
         err_ov_q    <= err_ov_d;
         busy_q      <= busy_d;
      end
   end

   // Entry storage; contents are only meaningful while counted as pending
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_val_q[wr_ptr_q] <= stim_i;
         mem_ts_q[wr_ptr_q]  <= ts_q;
      end
   end

   assign busy         = busy_q;
   assign edge_count   = edge_cnt_q;
   assign match_count  = match_cnt_q;
   assign last_lat     = last_lat_q;
   assign peak_lat     = peak_lat_q;
   assign err_timeout  = err_to_q;
   assign err_spurious = err_sp_q;
   assign err_overflow = err_ov_q;
   assign state        = state_q;

endmodule
